ps2_key_router: RTL and testbench



---
 rtl/ps2_key_router_if.sv | 31 +++
 rtl/ps2_key_router.sv | 144 ++++++++++++++
 tb/tb_ps2_key_router.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_router_if.sv
// Keyboard byte stream, ownership control and per-game press pulses for ps2_key_router.
interface ps2_key_router_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic       switch_lock;
  logic       owner;
  logic       switch_denied;
  logic       blk_left_press;
  logic       blk_right_press;
  logic       blk_down_press;
  logic       blk_play_press;
  logic       blk_restart_press;
  logic       snk_left_press;
  logic       snk_right_press;
  logic       snk_up_press;
  logic       snk_down_press;

  modport master (
    output ps2_byte, ps2_byte_valid, switch_lock,
    input  owner, switch_denied,
    input  blk_left_press, blk_right_press, blk_down_press, blk_play_press, blk_restart_press,
    input  snk_left_press, snk_right_press, snk_up_press, snk_down_press
  );

  modport slave (
    input  ps2_byte, ps2_byte_valid, switch_lock,
    output owner, switch_denied,
    output blk_left_press, blk_right_press, blk_down_press, blk_play_press, blk_restart_press,
    output snk_left_press, snk_right_press, snk_up_press, snk_down_press
  );
endinterface

// File: rtl/ps2_key_router.sv
// Parses PS/2 scan codes, tracks held keys and routes fresh key-down pulses to the
// game that owns the keyboard; Tab hands ownership over.
//   state     | meaning
//   S_IDLE    | no prefix pending
//   S_EXT     | E0 seen, next code is extended
//   S_BRK     | F0 seen, next code is a release
//   S_EXT_BRK | E0 F0 seen, next code is an extended release
module ps2_key_router #(
  parameter int TIMEOUT_CYCLES = 250000,
  parameter bit OWNER_RESET    = 1'b0
) (
  input logic              CLK_50M,
  input logic              RSTn,
  ps2_key_router_if.slave  kb
);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  localparam logic [17:0] TMO_LAST = 18'(TIMEOUT_CYCLES - 1);

  // held/key one-hot bit order: LEFT RIGHT UP DOWN P R TAB (bit 0 .. bit 6)
  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_UP    = 2;
  localparam int K_DOWN  = 3;
  localparam int K_P     = 4;
  localparam int K_R     = 5;
  localparam int K_TAB   = 6;

  state_t      state_q, state_d;
  logic [17:0] tmo_q, tmo_d;
  logic [6:0]  held_q, held_d;
  logic        owner_q, owner_d;
  logic [4:0]  blk_q, blk_d;
  logic [3:0]  snk_q, snk_d;
  logic        denied_q, denied_d;

  logic       is_ext, is_brk;
  logic [6:0] key_oh;

  always_comb begin
    is_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    is_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    key_oh = '0;
    if (is_ext) begin
      case (kb.ps2_byte)
        8'h6B:   key_oh[K_LEFT]  = 1'b1;
        8'h74:   key_oh[K_RIGHT] = 1'b1;
        8'h75:   key_oh[K_UP]    = 1'b1;
        8'h72:   key_oh[K_DOWN]  = 1'b1;
        default: key_oh = '0;
      endcase
    end else begin
      case (kb.ps2_byte)
        8'h4D:   key_oh[K_P]   = 1'b1;
        8'h2D:   key_oh[K_R]   = 1'b1;
        8'h0D:   key_oh[K_TAB] = 1'b1;
        default: key_oh = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    held_d   = held_q;
    owner_d  = owner_q;
    blk_d    = '0;
    snk_d    = '0;
    denied_d = 1'b0;
    if (kb.ps2_byte_valid) begin
      // A byte always wins over a coinciding timeout expiry.
      tmo_d = '0;
      case (kb.ps2_byte)
        8'hE0: state_d = S_EXT;
        8'hF0: begin
          if (state_q == S_IDLE)     state_d = S_BRK;
          else if (state_q == S_EXT) state_d = S_EXT_BRK;
        end
        8'hE1: state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          if (is_brk) begin
            held_d = held_q & ~key_oh;
          end else if ((key_oh != '0) && ((held_q & key_oh) == '0)) begin
            held_d = held_q | key_oh;
            if (key_oh[K_TAB]) begin
              if (kb.switch_lock) begin
                denied_d = 1'b1;
              end else begin
                owner_d = ~owner_q;
                held_d  = 7'b100_0000;
              end
            end else if (!owner_q) begin
              blk_d = {key_oh[K_R], key_oh[K_P], key_oh[K_DOWN], key_oh[K_RIGHT], key_oh[K_LEFT]};
            end else begin
              snk_d = {key_oh[K_DOWN], key_oh[K_UP], key_oh[K_RIGHT], key_oh[K_LEFT]};
            end
          end
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else if (tmo_q != '1) begin
        tmo_d = tmo_q + 18'd1;
      end
    end
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      held_q   <= '0;
      owner_q  <= OWNER_RESET;
      blk_q    <= '0;
      snk_q    <= '0;
      denied_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      held_q   <= held_d;
      owner_q  <= owner_d;
      blk_q    <= blk_d;
      snk_q    <= snk_d;
      denied_q <= denied_d;
    end
  end

  assign kb.owner             = owner_q;
  assign kb.switch_denied     = denied_q;
  assign kb.blk_left_press    = blk_q[0];
  assign kb.blk_right_press   = blk_q[1];
  assign kb.blk_down_press    = blk_q[2];
  assign kb.blk_play_press    = blk_q[3];
  assign kb.blk_restart_press = blk_q[4];
  assign kb.snk_left_press    = snk_q[0];
  assign kb.snk_right_press   = snk_q[1];
  assign kb.snk_up_press      = snk_q[2];
  assign kb.snk_down_press    = snk_q[3];

endmodule

// File: tb/tb_ps2_key_router.sv
// Scoreboard bench for ps2_key_router: a key-level reference model predicts output
// events into a queue, an independent monitor pops and compares whatever the DUT emits.
module tb_ps2_key_router;
  localparam int T = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_router_if kb();

  ps2_key_router #(.TIMEOUT_CYCLES(T), .OWNER_RESET(1'b0)) dut (
    .CLK_50M(clk),
    .RSTn   (rst_n),
    .kb     (kb)
  );

  // event vector: [10] owner toggled, [9] denied, [8:5] snk down/up/right/left,
  // [4:0] blk restart/play/down/right/left
  typedef struct {
    logic [10:0] vec;
    int          cyc;
    logic        own;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_cnt = 0;
  int   cnt[11];

  // reference model: prefix flags, held set, owner, edge of last byte
  bit       m_ext, m_brk, m_own;
  bit [6:0] m_held;
  int       m_last_edge;
  // key ids 0..6 = LEFT RIGHT UP DOWN P R TAB; where each one lands per owner
  int blk_bit[7] = '{0, 1, -1, 2, 3, 4, -1};
  int snk_bit[7] = '{5, 6, 7, 8, -1, -1, -1};

  always @(posedge clk) cyc_cnt = cyc_cnt + 1;

  function automatic int key_of(bit ext, logic [7:0] b);
    if (ext) begin
      case (b)
        8'h6B: return 0;
        8'h74: return 1;
        8'h75: return 2;
        8'h72: return 3;
        default: return -1;
      endcase
    end
    case (b)
      8'h4D: return 4;
      8'h2D: return 5;
      8'h0D: return 6;
      default: return -1;
    endcase
  endfunction

  task automatic push(int bit_i, int edge_i);
    exp_t e;
    e.vec = '0;
    e.vec[bit_i] = 1'b1;
    e.cyc = edge_i;
    e.own = m_own;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(logic [7:0] b, bit lock, int edge_i);
    int k;
    if ((m_ext || m_brk) && (edge_i - m_last_edge > T)) begin
      m_ext = 0;
      m_brk = 0;
    end
    m_last_edge = edge_i;
    if (b == 8'hE0) begin
      m_ext = 1; m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE1) begin
      m_ext = 0; m_brk = 0;
    end else begin
      k = key_of(m_ext, b);
      if (k >= 0) begin
        if (m_brk) m_held[k] = 1'b0;
        else if (!m_held[k]) begin
          m_held[k] = 1'b1;
          if (k == 6) begin
            if (lock) push(9, edge_i);
            else begin
              m_own  = ~m_own;
              m_held = 7'b100_0000;
              push(10, edge_i);
            end
          end else if (!m_own && blk_bit[k] >= 0) push(blk_bit[k], edge_i);
          else if (m_own && snk_bit[k] >= 0) push(snk_bit[k], edge_i);
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  // monitor
  logic prev_own = 1'b0;
  always @(negedge clk) begin
    logic [10:0] obs;
    exp_t e;
    if (!rst_n) prev_own = 1'b0;
    else begin
      obs = {kb.owner != prev_own, kb.switch_denied,
             kb.snk_down_press, kb.snk_up_press, kb.snk_right_press, kb.snk_left_press,
             kb.blk_restart_press, kb.blk_play_press, kb.blk_down_press,
             kb.blk_right_press, kb.blk_left_press};
      for (int i = 0; i < 11; i++) if (obs[i]) cnt[i] = cnt[i] + 1;
      if (obs != '0) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_event cyc=%0d got=%b required=none", cyc_cnt, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e.vec || cyc_cnt != e.cyc || kb.owner !== e.own) begin
            bad = bad + 1;
            $display("FAIL event got=%b@%0d owner=%b required=%b@%0d owner=%b",
                     obs, cyc_cnt, kb.owner, e.vec, e.cyc, e.own);
          end
        end
      end
      prev_own = kb.owner;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    model_byte(b, kb.switch_lock, cyc_cnt + 1);
    kb.ps2_byte = b;
    kb.ps2_byte_valid = 1'b1;
    cyc();
    kb.ps2_byte_valid = 1'b0;
  endtask

  // place the next strobe exactly `gap` edges after the previous one
  task automatic send_gap(logic [7:0] b, int gap);
    while (cyc_cnt + 1 < m_last_edge + gap) cyc();
    send_byte(b);
  endtask

  task automatic drain(string name);
    repeat (3) cyc();
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL %s missing_events got=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_int(string name, int got, int req);
    total = total + 1;
    if (got != req) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ext = 0; m_brk = 0; m_held = '0; m_own = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    int base;
    int g;
    logic [7:0] b;
    logic [7:0] pool[12] = '{8'hE0, 8'hF0, 8'hE1, 8'h6B, 8'h74, 8'h75,
                             8'h72, 8'h4D, 8'h2D, 8'h0D, 8'hE0, 8'hF0};
    for (int i = 0; i < 11; i++) cnt[i] = 0;
    kb.ps2_byte = '0;
    kb.ps2_byte_valid = 1'b0;
    kb.switch_lock = 1'b0;
    m_last_edge = 0;
    do_reset();

    check_int("reset_owner", int'(kb.owner), 0);
    check_int("reset_outputs", int'({kb.switch_denied, kb.snk_down_press, kb.snk_up_press,
              kb.snk_right_press, kb.snk_left_press, kb.blk_restart_press, kb.blk_play_press,
              kb.blk_down_press, kb.blk_right_press, kb.blk_left_press}), 0);

    send_byte(8'hE0); send_byte(8'h6B);
    drain("ext_left");
    check_int("left_count", cnt[0], 1);
    check_int("snk_quiet", cnt[5] + cnt[6] + cnt[7] + cnt[8], 0);

    repeat (3) send_byte(8'h4D);
    send_byte(8'hF0); send_byte(8'h4D); send_byte(8'h4D);
    drain("typematic");
    check_int("play_count", cnt[3], 2);

    kb.switch_lock = 1'b0;
    send_byte(8'h0D);
    drain("tab_switch");
    check_int("owner_after_tab", int'(kb.owner), 1);
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'h2D);
    drain("snake_up");
    check_int("snk_up_count", cnt[7], 1);
    check_int("restart_dropped", cnt[4], 0);

    send_byte(8'hF0); send_byte(8'h0D);
    kb.switch_lock = 1'b1;
    send_byte(8'h0D);
    drain("tab_locked");
    check_int("denied_count", cnt[9], 1);
    check_int("owner_locked", int'(kb.owner), 1);
    send_byte(8'hF0); send_byte(8'h0D);
    kb.switch_lock = 1'b0;
    send_byte(8'h0D);
    drain("tab_unlocked");
    check_int("owner_back", int'(kb.owner), 0);

    base = cnt[0];
    send_byte(8'hE0); send_gap(8'h6B, T + 1);
    drain("timeout_late");
    check_int("timeout_late_left", cnt[0] - base, 0);
    send_byte(8'hE0); send_gap(8'h6B, T);
    drain("timeout_expiry_cycle");
    check_int("timeout_edge_left", cnt[0] - base, 1);

    send_byte(8'hE0); send_byte(8'h72);
    send_byte(8'hE0); send_byte(8'hF0);
    do_reset();
    send_byte(8'h72);
    drain("reset_midseq");
    check_int("down_before_reset", cnt[2], 1);
    send_byte(8'hE0); send_byte(8'h72);
    drain("held_cleared_by_reset");
    check_int("down_after_reset", cnt[2], 2);

    for (int i = 0; i < 1500; i++) begin
      g = $urandom_range(0, 15);
      if (g < 12) b = pool[g];
      else b = 8'($urandom);
      kb.switch_lock = ($urandom_range(0, 3) == 0);
      g = $urandom_range(0, 19);
      if (g >= 17) repeat ($urandom_range(1, 3)) cyc();
      if (g == 18) send_gap(b, T);
      else if (g == 19) send_gap(b, T + 1);
      else send_byte(b);
      if (i % 100 == 99) drain("random_block");
      if ($urandom_range(0, 249) == 0) begin
        drain("pre_reset");
        do_reset();
      end
    end
    drain("random_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
